para_add_sub: RTL and testbench

//   WIDTH-bit ripple-carry parallel adder/subtractor with a registered result.
//   M=0 selects A1+B1; M=1 selects A1-B1, computed as A1 + ~B1 + 1.

---
 rtl/para_add_sub.sv | 49 ++++
 tb/tb_para_add_sub.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/para_add_sub.sv
`timescale 1ns/1ps
// Purpose: WIDTH-bit ripple-carry adder/subtractor; M=1 computes A1 + ~B1 + 1, carry-out kept as result MSB.
// Latency: exactly one clk; the result for the inputs sampled at edge n is visible after edge n.
// Backpressure: none; a new result is registered every cycle with no enable or stall.
module para_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             M,
  output logic [WIDTH:0]   sum2
);

  // Per-stage full-adder signals; the carry chain is carried in a scalar that
  // is updated bit by bit so each stage only sees the carry of the stage below.
  logic [WIDTH-1:0] s_c;
  logic             carry_c;
  logic             b_c;
  logic [WIDTH:0]   sum2_d;
  logic [WIDTH:0]   sum2_q;

  // Ripple chain: B is conditionally inverted by M and M is also the carry-in,
  // which turns the adder into A1 + ~B1 + 1 for subtraction.
  always_comb begin
    carry_c = M;
    b_c     = 1'b0;
    s_c     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b_c     = B1[i] ^ M;
      s_c[i]  = A1[i] ^ b_c ^ carry_c;
      carry_c = (A1[i] & b_c) | (carry_c & (A1[i] ^ b_c));
    end
    sum2_d = {carry_c, s_c};
  end

  // Result register; reset clears immediately and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum2_q <= '0;
    end else begin
      sum2_q <= sum2_d;
    end
  end

  assign sum2 = sum2_q;

endmodule

// File: tb/tb_para_add_sub.sv
`timescale 1ns/1ps
// Testbench for para_add_sub: directed spec vectors, reset behaviour,
// randomized back-to-back traffic and an exhaustive sweep against a model.
module tb_para_add_sub;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A1;
  logic [W-1:0] B1;
  logic         M;
  logic [W:0]   sum2;

  int errors = 0;
  int checks = 0;

  para_add_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A1   (A1),
    .B1   (B1),
    .M    (M),
    .sum2 (sum2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, truncated to W+1 bits.
  function automatic logic [W:0] ref_model(input int a, input int b, input int m);
    int r;
    r = (m != 0) ? (a + ((~b) & MASK) + 1) : (a + b);
    return r[W:0];
  endfunction

  task automatic drive(input int a, input int b, input int m);
    A1 = a[W-1:0];
    B1 = b[W-1:0];
    M  = m[0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(15, 15, 0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (sum2 !== 5'b00000)
        $display("FAIL reset_hold: sum2=%b expected=%b", sum2, 5'b00000);
        if (sum2 !== 5'b00000) errors++;
    end
    // Release between edges; the first edge must load a valid result.
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (sum2 !== 5'b11110) begin
      errors++;
      $display("FAIL reset_release: sum2=%b expected=%b", sum2, 5'b11110);
    end
    // Asynchronous assertion between edges clears at once.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sum2 !== 5'b00000) begin
      errors++;
      $display("FAIL reset_async: sum2=%b expected=%b", sum2, 5'b00000);
    end
    // Pending result across an edge held in reset is discarded.
    drive(12, 3, 0);
    @(negedge clk);
    checks++;
    if (sum2 !== 5'b00000) begin
      errors++;
      $display("FAIL reset_discard: sum2=%b expected=%b", sum2, 5'b00000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (sum2 !== 5'b01111) begin
      errors++;
      $display("FAIL reset_resume: sum2=%b expected=%b", sum2, 5'b01111);
    end
  endtask

  // Directed vectors from the data sheet: {a, b, m, expected}.
  task automatic test_directed();
    int         ta [11] = '{0, 15, 4, 12, 14, 15, 15, 13, 15, 8, 9};
    int         tb [11] = '{0, 15, 5, 3, 13, 7, 15, 7, 9, 15, 15};
    int         tm [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic [W:0] te [11] = '{5'b00000, 5'b11110, 5'b01001, 5'b01111, 5'b11011,
                            5'b11000, 5'b10000, 5'b10110, 5'b10110, 5'b01001, 5'b01010};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i], tm[i]);
      @(negedge clk);
      checks++;
      if (sum2 !== te[i]) begin
        errors++;
        $display("FAIL directed_%0d (%0d %s %0d): sum2=%b expected=%b",
                 i, ta[i], (tm[i] != 0) ? "-" : "+", tb[i], sum2, te[i]);
      end
    end
    // Borrow cases: low nibble as a signed value must be the true difference.
    @(negedge clk);
    drive(8, 15, 1);
    @(negedge clk);
    checks++;
    if ($signed(sum2[W-1:0]) !== -4'sd7) begin
      errors++;
      $display("FAIL borrow_neg7: low=%0d expected=-7", $signed(sum2[W-1:0]));
    end
    drive(9, 15, 1);
    @(negedge clk);
    checks++;
    if ($signed(sum2[W-1:0]) !== -4'sd6) begin
      errors++;
      $display("FAIL borrow_neg6: low=%0d expected=-6", $signed(sum2[W-1:0]));
    end
  endtask

  // M flipping after the sampling edge must not disturb the registered result.
  task automatic test_mode_glitch();
    logic [W:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      int a, b, m;
      a = $urandom_range(MASK, 0);
      b = $urandom_range(MASK, 0);
      m = $urandom_range(1, 0);
      @(negedge clk);
      drive(a, b, m);
      exp_v = ref_model(a, b, m);
      @(posedge clk);
      #1 M = ~M;
      @(negedge clk);
      checks++;
      if (sum2 !== exp_v) begin
        errors++;
        $display("FAIL mode_glitch_%0d: sum2=%b expected=%b", i, sum2, exp_v);
      end
    end
  endtask

  // New random operands every cycle; each result checked one cycle later.
  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    for (int i = 0; i < 200; i++) begin
      int a, b, m;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [W:0] e;
        e = exp_q.pop_front();
        checks++;
        if (sum2 !== e) begin
          errors++;
          $display("FAIL back_to_back_%0d: sum2=%b expected=%b", i, sum2, e);
        end
      end
      a = $urandom_range(MASK, 0);
      b = $urandom_range(MASK, 0);
      m = $urandom_range(1, 0);
      drive(a, b, m);
      exp_q.push_back(ref_model(a, b, m));
    end
    @(negedge clk);
    checks++;
    if (sum2 !== exp_q[0]) begin
      errors++;
      $display("FAIL back_to_back_last: sum2=%b expected=%b", sum2, exp_q[0]);
    end
  endtask

  // Every operand/mode combination, streamed one per cycle.
  task automatic test_exhaustive();
    logic [W:0] exp_v;
    bit         have;
    have  = 1'b0;
    exp_v = '0;
    for (int v = 0; v < (1 << (2 * W + 1)); v++) begin
      @(negedge clk);
      if (have) begin
        checks++;
        if (sum2 !== exp_v) begin
          errors++;
          $display("FAIL exhaustive_%0d: sum2=%b expected=%b", v - 1, sum2, exp_v);
        end
      end
      drive(v & MASK, (v >> W) & MASK, (v >> (2 * W)) & 1);
      exp_v = ref_model(v & MASK, (v >> W) & MASK, (v >> (2 * W)) & 1);
      have  = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (sum2 !== exp_v) begin
      errors++;
      $display("FAIL exhaustive_last: sum2=%b expected=%b", sum2, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    A1    = '0;
    B1    = '0;
    M     = 1'b0;
    test_reset();
    test_directed();
    test_mode_glitch();
    test_back_to_back();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
